// File: rtl/reg_pkg.sv
// Shared constants and state encoding for the register readback streamer.
// Address increment wraps naturally because NUM_REGS is a power of two.
package reg_pkg;

  localparam int WIDTH    = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic [ADDR_W-1:0] addr_inc(
    input logic [ADDR_W-1:0] a
  );
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/reg_read_addr_counter.sv
// Loadable entry counter for the readback walk.
// Holds the current and final entry and flags when they match.
module reg_read_addr_counter
  import reg_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] ld_cur,
  input  logic [ADDR_W-1:0] ld_last,
  output logic [ADDR_W-1:0] cur,
  output logic              at_last
);

  logic [ADDR_W-1:0] cur_d, cur_q;
  logic [ADDR_W-1:0] last_d, last_q;

  always_comb begin
    cur_d  = cur_q;
    last_d = last_q;
    if (load) begin
      cur_d  = ld_cur;
      last_d = ld_last;
    end else if (inc) begin
      cur_d = addr_inc(cur_q);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur_q  <= '0;
      last_q <= '0;
    end else begin
      cur_q  <= cur_d;
      last_q <= last_d;
    end
  end

  assign cur     = cur_q;
  assign at_last = (cur_q == last_q);

endmodule

// File: rtl/reg_readback_streamer.sv
// Walks a register-file range through a synchronous read port
// and streams each captured word out on a valid/ready interface.
module reg_readback_streamer
  import reg_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [WIDTH-1:0]  rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e            state_d, state_q;
  logic [WIDTH-1:0]  out_data_d, out_data_q;
  logic [ADDR_W-1:0] out_addr_d, out_addr_q;
  logic              out_valid_d, out_valid_q;
  logic              out_last_d, out_last_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              cnt_load, cnt_inc;
  logic [ADDR_W-1:0] cur;
  logic              at_last;

  reg_read_addr_counter u_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .ld_cur  (start_addr),
    .ld_last (end_addr),
    .cur     (cur),
    .at_last (at_last)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          out_data_d  = rf_data;
          out_addr_d  = cur;
          out_last_d  = at_last;
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        // an aborted word is dropped, never counted as transferred
        if (abort) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (at_last) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf_addr   = cur;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_readback_streamer.sv
// Scoreboard bench for reg_readback_streamer.
// Register file model holds entry i = 16'h1000 + i.
module tb_reg_readback_streamer;
  import reg_pkg::*;

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  int     xfer_cyc = 0;
  word_t  exp_q[$];

  reg_readback_streamer dut (
    .CLK        (clk),
    .RST        (rst_n),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rf_data <= 16'h1000 + 16'(rf_addr);
    cyc     <= cyc + 1;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // monitor: a word is transferred when valid & ready and no abort
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready && !abort) begin
        xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_data", 32'(out_data), 32'(w.data));
          chk("word_addr", 32'(out_addr), 32'(w.addr));
          chk("word_last", 32'(out_last), 32'(w.last));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a,
                           input logic l);
    word_t w;
    w.data = 16'h1000 + 16'(a);
    w.addr = a;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic push_range(input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] e);
    logic [ADDR_W-1:0] a;
    a = s;
    for (int i = 0; i < NUM_REGS; i++) begin
      push_word(a, a == e);
      if (a == e) break;
      a = a + ADDR_W'(1);
    end
  endtask

  task automatic kick(input logic [ADDR_W-1:0] s,
                      input logic [ADDR_W-1:0] e);
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit seen;
    seen = 0;
    dc   = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) begin
        seen = 1;
        dc   = cyc;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_word(input logic [ADDR_W-1:0] a);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (out_valid && out_addr == a) begin
        seen = 1;
        break;
      end
    end
    chk("word_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int dc;
    int d0;
    logic [WIDTH-1:0]  hd;
    logic [ADDR_W-1:0] ha;

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // 1) basic range 2..4 with latency check
    push_range(4'd2, 4'd4);
    kick(4'd2, 4'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_lat_k1", 32'(out_valid), 32'd0);
    step();
    chk("t1_lat_k2", 32'(out_valid), 32'd1);
    chk("t1_first_addr", 32'(out_addr), 32'd2);
    d0 = done_cnt;
    wait_done(dc);
    chk("t1_done_after_xfer", 32'(dc), 32'(xfer_cyc + 1));
    chk("t1_busy_in_done", 32'(busy), 32'd1);
    step();
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_done_fall", 32'(done), 32'd0);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2) wrap-around 14..1
    push_range(4'd14, 4'd1);
    kick(4'd14, 4'd1);
    wait_done(dc);
    step();
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3) backpressure on first word
    out_ready = 1'b0;
    push_range(4'd0, 4'd1);
    kick(4'd0, 4'd1);
    wait_word(4'd0);
    hd = out_data;
    ha = out_addr;
    chk("t3_hold_data0", 32'(hd), 32'h1000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_data", 32'(out_data), 32'(hd));
      chk("t3_hold_addr", 32'(out_addr), 32'(ha));
    end
    out_ready = 1'b1;
    wait_done(dc);
    step();
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4) single word 7..7
    push_range(4'd7, 4'd7);
    kick(4'd7, 4'd7);
    wait_done(dc);
    chk("t4_done_after_xfer", 32'(dc), 32'(xfer_cyc + 1));
    step();
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5) abort during SEND of the second word
    push_word(4'd8, 1'b0);
    d0 = done_cnt;
    kick(4'd8, 4'd11);
    wait_word(4'd9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    repeat (4) step();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
    push_range(4'd3, 4'd3);
    kick(4'd3, 4'd3);
    wait_done(dc);
    step();
    chk("t5_restart_q", 32'(exp_q.size()), 32'd0);

    // 6) async reset in CAPT, then restart; start while busy ignored
    kick(4'd5, 4'd6);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("t6_rst_out_addr", 32'(out_addr), 32'd0);
    chk("t6_rst_out_data", 32'(out_data), 32'd0);
    #10 rst_n = 1'b1;
    step();
    push_range(4'd1, 4'd3);
    kick(4'd1, 4'd3);
    start_addr = 4'd10;
    end_addr   = 4'd12;
    start      = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_done(dc);
    step();
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
